// File: rtl/pit_irq_ctrl.sv
// Interrupt capture and prioritisation stage for minipit timers: edge-detects each
// source into a pending bit, presents one masked fixed-priority irq, counts lost edges.
module pit_irq_ctrl #(
    parameter int                 NUM_SRC    = 4,
    parameter int                 ID_W       = 2,
    parameter int                 CNT_W      = 8,
    parameter logic [NUM_SRC-1:0] MASK_RESET = {NUM_SRC{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               ack,
    input  logic [ID_W-1:0]    ack_id,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic [CNT_W-1:0]   missed_count
);

    // Wide enough to hold the counter plus up to 16 misses in one cycle.
    localparam int               SUM_W   = CNT_W + 5;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] missed;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] eff;
    logic [SUM_W-1:0]   miss_num;
    logic [SUM_W-1:0]   cnt_sum;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               irq_nxt;
    logic [ID_W-1:0]    id_nxt;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        rise = src_in & ~src_prev;
        clr  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Out-of-range ack_id never matches any i, so it is silently ignored.
            clr[i] = ack && (ack_id == ID_W'(i));
        end
        // A new edge on a still-pending source is lost unless the same cycle acks it.
        missed      = rise & ~clr & pending;
        pending_nxt = (pending & ~clr) | rise;

        miss_num = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            miss_num = miss_num + SUM_W'(missed[i]);
        end
        cnt_sum = SUM_W'(missed_count) + miss_num;
        cnt_nxt = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // Fixed priority: scan downward so the lowest set index is written last.
    always_comb begin
        eff     = pending & mask;
        irq_nxt = |eff;
        id_nxt  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eff[i]) id_nxt = ID_W'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev     <= '0;
            pending      <= '0;
            mask         <= MASK_RESET;
            missed_count <= '0;
            irq          <= 1'b0;
            irq_id       <= '0;
        end else begin
            src_prev     <= src_in;
            pending      <= pending_nxt;
            missed_count <= cnt_nxt;
            irq          <= irq_nxt;
            irq_id       <= id_nxt;
            if (mask_we) mask <= mask_wdata;
        end
    end

endmodule
